// File: rtl/cmos_pixel_pack_if.sv
// Pixel capture stream in, packed 128-bit write stream out.
// slave: the packer; master: the capture source / write sink side.
interface cmos_pixel_pack_if;
  logic [23:0]  pix_data;
  logic         pix_valid;
  logic         pix_sop;
  logic         pix_eop;
  logic [127:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_sof;
  logic         wr_eof;

  modport master (
    output pix_data, pix_valid, pix_sop, pix_eop, wr_ready,
    input  wr_data, wr_valid, wr_sof, wr_eof
  );

  modport slave (
    input  pix_data, pix_valid, pix_sop, pix_eop, wr_ready,
    output wr_data, wr_valid, wr_sof, wr_eof
  );
endinterface

// File: rtl/cmos_pixel_pack.sv
// Packs RGB888 pixels into 8 x RGB565 words; optional drop counter via CMOS_PACK_OVF_CNT_EN.
// Latency: word visible on wr_valid the cycle after its completing pixel (FWFT FIFO).
// Backpressure: none upstream; full FIFO without pop drops the word and resyncs at next pix_sop.

module cmos_pack_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 130
) (
  input  logic         cmos_pclk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_drop,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (count == FULL_CNT);
  assign out_vld = (count != '0);
  assign pop     = out_vld & out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = in_vld & (~full | pop);
  assign in_drop = in_vld & ~push;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end
endmodule

module cmos_pixel_pack #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  cmos_pixel_pack_if.slave  bus
`ifdef CMOS_PACK_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [127:0] dat;
    logic         sof;
    logic         eof;
  } pack_word_t;

  logic [0:0]   state;
  logic [2:0]   lane_idx;
  logic         sof_flg;
  logic [127:0] lane_buf;

  logic [15:0]  pix_565;
  logic         start_frame;
  logic         pix_take;
  logic [2:0]   fill_idx;
  logic [127:0] word_fill;
  logic         push_vld;
  logic         push_drop;
  pack_word_t   push_word;
  pack_word_t   head_word;

  assign pix_565     = {bus.pix_data[23:19], bus.pix_data[15:10], bus.pix_data[7:3]};
  assign start_frame = bus.pix_valid & bus.pix_sop;
  assign pix_take    = bus.pix_valid & (bus.pix_sop | (state == ST_RUN));
  assign fill_idx    = start_frame ? 3'd0 : lane_idx;

  // A sop pixel restarts the word from an all-zero buffer, discarding any partial.
  always_comb begin
    word_fill = start_frame ? 128'd0 : lane_buf;
    for (int n = 0; n < 8; n++) begin
      if (fill_idx == n[2:0]) word_fill[16*n +: 16] = pix_565;
    end
  end

  assign push_vld      = pix_take & (bus.pix_eop | (fill_idx == 3'd7));
  assign push_word.dat = word_fill;
  assign push_word.sof = start_frame | sof_flg;
  assign push_word.eof = bus.pix_eop;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lane_idx <= 3'd0;
      sof_flg  <= 1'b0;
      lane_buf <= '0;
    end else if (push_drop) begin
      state    <= ST_IDLE;
      lane_idx <= 3'd0;
      sof_flg  <= 1'b0;
      lane_buf <= '0;
    end else if (pix_take) begin
      if (push_vld) begin
        state    <= bus.pix_eop ? ST_IDLE : ST_RUN;
        lane_idx <= 3'd0;
        sof_flg  <= 1'b0;
        lane_buf <= '0;
      end else begin
        state    <= ST_RUN;
        lane_idx <= fill_idx + 3'd1;
        sof_flg  <= start_frame | sof_flg;
        lane_buf <= word_fill;
      end
    end
  end

  cmos_pack_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(pack_word_t))
  ) u_fifo (
    .cmos_pclk (cmos_pclk),
    .rst_n     (rst_n),
    .in_vld    (push_vld),
    .in_dat    (push_word),
    .in_drop   (push_drop),
    .out_vld   (bus.wr_valid),
    .out_dat   (head_word),
    .out_rdy   (bus.wr_ready)
  );

  assign bus.wr_data = head_word.dat;
  assign bus.wr_sof  = head_word.sof;
  assign bus.wr_eof  = head_word.eof;

`ifdef CMOS_PACK_OVF_CNT_EN
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 16'd0;
    end else if (push_drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Bench for cmos_pixel_pack: directed frames with literal expectations, then random traffic vs a queue model.
module tb_cmos_pixel_pack;
  localparam int DEPTH = 4;

  typedef struct {
    logic [127:0] dat;
    logic         sof;
    logic         eof;
  } word_t;

  logic cmos_pclk = 1'b0;
  logic rst_n     = 1'b0;
  always #5 cmos_pclk = ~cmos_pclk;

  cmos_pixel_pack_if bus();
`ifdef CMOS_PACK_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  cmos_pixel_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .cmos_pclk (cmos_pclk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef CMOS_PACK_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: frame-level view - a list of pending pixels and a queue of expected FIFO words.
  word_t       exp_q[$];
  word_t       log_q[$];
  logic [15:0] cur[$];
  bit          in_frame;
  bit          sof_pend;
  int          ovf_model;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    in_frame  = 0;
    sof_pend  = 0;
    ovf_model = 0;
  endtask

  task automatic model_edge(input logic v, input logic [23:0] d, input logic s,
                            input logic e, input logic rdy);
    bit    pop;
    bit    have;
    word_t w;
    pop  = (exp_q.size() > 0) && rdy;
    have = 0;
    w    = '{dat: '0, sof: 1'b0, eof: 1'b0};
    if (v) begin
      if (s) begin
        cur.delete();
        cur.push_back(to565(d));
        sof_pend = 1;
        in_frame = 1;
      end else if (in_frame) begin
        cur.push_back(to565(d));
      end
      if (in_frame && (e || cur.size() == 8)) begin
        foreach (cur[i]) w.dat[16*i +: 16] = cur[i];
        w.sof = sof_pend;
        w.eof = e;
        have  = 1;
        cur.delete();
        sof_pend = 0;
        if (e) in_frame = 0;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() >= DEPTH) begin
        in_frame = 0;
        sof_pend = 0;
        cur.delete();
        if (ovf_model < 65535) ovf_model++;
      end else begin
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_valid", bus.wr_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("wr_data", bus.wr_data, exp_q[0].dat);
      chk("wr_sof", bus.wr_sof, exp_q[0].sof);
      chk("wr_eof", bus.wr_eof, exp_q[0].eof);
    end
`ifdef CMOS_PACK_OVF_CNT_EN
    chk("ovf_cnt", ovf_cnt, ovf_model);
`endif
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic s,
                      input logic e, input logic rdy);
    @(negedge cmos_pclk);
    check_outputs();
    bus.pix_valid = v;
    bus.pix_data  = d;
    bus.pix_sop   = s;
    bus.pix_eop   = e;
    bus.wr_ready  = rdy;
    if (bus.wr_valid && rdy)
      log_q.push_back('{dat: bus.wr_data, sof: bus.wr_sof, eof: bus.wr_eof});
    if (rst_n) model_edge(v, d, s, e, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, 1'b0, rdy);
  endtask

  task automatic frame(input int n, input logic [23:0] pix, input bit rnd,
                       input bit with_eop, input logic rdy);
    for (int i = 0; i < n; i++)
      step(1'b1, rnd ? 24'($urandom) : pix, i == 0, with_eop && (i == n-1), rdy);
  endtask

  int sof_n, eof_n;

  initial begin
    bus.pix_valid = 0; bus.pix_data = '0; bus.pix_sop = 0; bus.pix_eop = 0; bus.wr_ready = 0;
    model_reset();
    repeat (3) @(negedge cmos_pclk);
    chk("rst_wr_valid", bus.wr_valid, 1'b0);
    chk("rst_wr_data", bus.wr_data, 128'h0);
    chk("rst_wr_sof", bus.wr_sof, 1'b0);
    chk("rst_wr_eof", bus.wr_eof, 1'b0);
`ifdef CMOS_PACK_OVF_CNT_EN
    chk("rst_ovf_cnt", ovf_cnt, 16'h0);
`endif
    rst_n = 1'b1;

    // Pixels without sop after reset produce nothing
    for (int i = 0; i < 10; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("nosop_words", log_q.size(), 0);

    // Red then green pixels
    log_q.delete();
    step(1'b1, 24'hFF0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 24'h00FF00, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("rg_words", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("rg_data", log_q[0].dat, {{7{16'h07E0}}, 16'hF800});
      chk("rg_sof", log_q[0].sof, 1'b1);
      chk("rg_eof", log_q[0].eof, 1'b0);
    end

    // 1280-pixel line
    log_q.delete();
    frame(1280, 24'h0, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    chk("line_words", log_q.size(), 160);
    sof_n = 0; eof_n = 0;
    foreach (log_q[i]) begin
      sof_n += int'(log_q[i].sof);
      eof_n += int'(log_q[i].eof);
    end
    chk("line_sof_cnt", sof_n, 1);
    chk("line_eof_cnt", eof_n, 1);
    if (log_q.size() == 160) begin
      chk("line_first_sof", log_q[0].sof, 1'b1);
      chk("line_last_eof", log_q[159].eof, 1'b1);
    end

    // 11-pixel frame
    log_q.delete();
    frame(11, 24'hFFFFFF, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("f11_words", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("f11_w0", log_q[0].dat, {128{1'b1}});
      chk("f11_w1", log_q[1].dat, {80'h0, 48'hFFFF_FFFF_FFFF});
      chk("f11_w1_eof", log_q[1].eof, 1'b1);
    end

    // sop mid-RUN after 3 pixels discards the partial word
    log_q.delete();
    frame(3, 24'h123456, 1'b0, 1'b0, 1'b1);
    step(1'b1, 24'hFF0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 24'h0000FF, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("resop_words", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("resop_data", log_q[0].dat, {{7{16'h001F}}, 16'hF800});
      chk("resop_sof", log_q[0].sof, 1'b1);
    end

    // Overflow: 5 full words with wr_ready low
    log_q.delete();
    frame(40, 24'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
    chk("ovf_model", ovf_model, 1);
    chk("ovf_hold_valid", bus.wr_valid, 1'b1);
    idle(8, 1'b1);
    chk("ovf_drained", log_q.size(), 4);

    // Async reset with 2 words queued and 5 lanes filled
    log_q.delete();
    frame(21, 24'h0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.wr_valid, 1'b0);
    chk("arst_data", bus.wr_data, 128'h0);
    model_reset();
    bus.pix_valid = 0; bus.wr_ready = 1;
    idle(2, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("arst_no_stale", log_q.size(), 0);

    // Random traffic, alternating downstream pressure
    for (int c = 0; c < 6000; c++) begin
      logic rdy;
      case ((c / 500) % 3)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 9) < 3);
        default: rdy = ($urandom_range(0, 9) < 9);
      endcase
      step($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 39) == 0,
           $urandom_range(0, 39) == 0, rdy);
    end
    idle(10, 1'b1);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmos_pixel_pack.md
CMOS_PIXEL_PACK -- requirements
Module: cmos_pixel_pack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO depth (power of two, >=2).
REQ-002 SHALL have port cmos_pclk  input  1  pixel clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pix_data  input  24  RGB888 pixel {R[7:0],G[7:0],B[7:0]} from the capture stage.
REQ-005 SHALL have port pix_valid  input  1  pix_data valid this cycle.
REQ-006 SHALL have port pix_sop  input  1  first pixel of frame; qualified by pix_valid.
REQ-007 SHALL have port pix_eop  input  1  last pixel of frame; qualified by pix_valid.
REQ-008 SHALL have port wr_data  output  128  packed word of 8 RGB565 pixels.
REQ-009 SHALL have port wr_valid  output  1  wr_data/wr_sof/wr_eof valid.
REQ-010 SHALL have port wr_ready  input  1  downstream (DDR write FIFO) accepts word.
REQ-011 SHALL have port wr_sof  output  1  word holds first pixel of frame.
REQ-012 SHALL have port wr_eof  output  1  word holds last pixel of frame.
REQ-013 SHALL have port ovf_cnt  output  16  dropped-word count (present only with macro, see Configuration).

Function
REQ-014 SHALL convert each pixel to RGB565 as {pix_data[23:19], pix_data[15:10], pix_data[7:3]}.
REQ-015 SHALL place pixel n of a word (n=0..7, arrival order) at wr_data[16n+15:16n]; pixel 0 in LSBs.
REQ-016 SHALL implement states IDLE, RUN; pixels with pix_valid=0 ignored in all states.
REQ-017 IDLE: pixels without pix_sop discarded; pix_valid&pix_sop -> lane 0 loaded, sof flag set, go RUN.
REQ-018 RUN: each valid pixel fills next lane; on lane 7 filled, word pushed to FIFO with stored sof flag, sof flag cleared, lane index wraps to 0.
REQ-019 RUN, valid pixel with pix_eop: pixel stored, word pushed (unfilled lanes zero), eof=1, go IDLE; applies also when eop lands on lane 7 (single push).
REQ-020 RUN, valid pixel with pix_sop: partial word discarded without push, pixel loaded into lane 0 with sof set, remain RUN.
REQ-021 pix_sop and pix_eop on same valid pixel: one-pixel frame, word pushed with sof=1, eof=1, lanes 1..7 zero, state IDLE.
REQ-022 Push SHALL occur on the edge capturing the completing pixel; word visible at wr_valid no earlier than the following cycle.
REQ-023 wr_valid SHALL equal FIFO not-empty; pop on wr_valid & wr_ready; wr_data/wr_sof/wr_eof stable while wr_valid & !wr_ready.
REQ-024 Simultaneous push and pop on full FIFO SHALL succeed (no drop).
REQ-025 Push on full FIFO without pop: word dropped, state forced to IDLE (resync at next pix_sop), ovf_cnt +1 saturating at 16'hFFFF.
REQ-026 FIFO SHALL be first-word-fall-through; occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, lane index 0, sof flag 0, FIFO empty, wr_valid 0, wr_data 0, wr_sof 0, wr_eof 0, ovf_cnt 0.
REQ-028 Reset mid-frame SHALL discard partial word and FIFO contents; after release first accepted pixel is next pix_sop.

Configuration
REQ-029 Macro CMOS_PACK_OVF_CNT_EN defined: ovf_cnt port and counter present per REQ-025.
REQ-030 Macro undefined: ovf_cnt port and counter absent; drop and IDLE resync behaviour unchanged.

Verification
REQ-031 wr_ready=1, sop pixel 0xFF0000 then 7 pixels 0x00FF00 -> one word, lane0=16'hF800, lanes1..7=16'h07E0, wr_sof=1, wr_eof=0.
REQ-032 wr_ready=1, 1280-pixel frame with sop/eop -> 160 words, first wr_sof=1, last wr_eof=1, no others flagged.
REQ-033 Frame of 11 pixels -> 2 words; second has lanes 0..2 valid, lanes 3..7 = 0, wr_eof=1.
REQ-034 wr_ready=0, FIFO_DEPTH=4, 5 full words pushed -> wr_valid held, 5th dropped, ovf_cnt=1, pixels ignored until next pix_sop.
REQ-035 Pixels without pix_sop after reset -> no words; sop mid-RUN after 3 pixels -> partial discarded, next word starts with sop pixel, wr_sof=1.
REQ-036 rst_n asserted with 2 words queued and 5 lanes filled -> wr_valid=0 immediately, no stale words after release.
